// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-read-port register file.
// Holds the clear/ready state encoding and the depth calculation.
package regfile_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } rf_state_t;

   function automatic int calc_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Reset sequencer: walks every entry once after reset, writing zero; 1 entry/cycle, DEPTH cycles.
// External writes arriving during the walk are dropped and flagged one cycle later on o_wr_drop.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_wen,
   output logic                  o_busy,
   output logic                  o_wr_drop,
   output logic                  o_clr_we,
   output logic [ADDR_WIDTH-1:0] o_clr_addr
);

   localparam int DEPTH = calc_depth(ADDR_WIDTH);
   localparam int CNT_W = ADDR_WIDTH + 1;

   rf_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_wr_drop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= CLEAR;
         r_cnt     <= '0;
         r_busy    <= 1'b1;
         r_wr_drop <= 1'b0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_cnt     <= r_cnt + CNT_W'(1);
               r_wr_drop <= i_wen;
               if (r_cnt == CNT_W'(DEPTH - 1)) begin
                  r_state <= READY;
                  r_busy  <= 1'b0;
               end
            end
            READY: begin
               r_wr_drop <= 1'b0;
            end
            default: begin
               r_state <= CLEAR;
               r_cnt   <= '0;
               r_busy  <= 1'b1;
            end
         endcase
      end
   end

   // No array write while reset is held, so the walk always restarts cleanly at entry 0.
   assign o_clr_we   = (r_state == CLEAR) && !rst;
   assign o_clr_addr = r_cnt[ADDR_WIDTH-1:0];
   assign o_busy     = r_busy;
   assign o_wr_drop  = r_wr_drop;

endmodule

// File: rtl/regfile_multiport.sv
// Integer register file: one write port, NUM_READ combinational read ports, optional bypass and zero register.
// Reads 0 while the post-reset clear runs; writes during the clear are dropped and flagged on wr_drop.
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_READ   = 2,
   parameter int BYPASS     = 1,
   parameter int ZERO_REG   = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wen,
   input  logic [ADDR_WIDTH-1:0]          waddr,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
   output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
   output logic                           busy,
   output logic                           wr_drop
);

   localparam int DEPTH = calc_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] r_rf [DEPTH];

   logic                  w_busy;
   logic                  w_clr_we;
   logic [ADDR_WIDTH-1:0] w_clr_addr;
   logic                  w_zero_hit;
   logic                  w_ext_we;
   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_waddr;
   logic [DATA_WIDTH-1:0] w_wdata;

   regfile_clear_seq #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clear_seq (
      .clk        (clk),
      .rst        (rst),
      .i_wen      (wen),
      .o_busy     (w_busy),
      .o_wr_drop  (wr_drop),
      .o_clr_we   (w_clr_we),
      .o_clr_addr (w_clr_addr)
   );

   assign busy       = w_busy;
   assign w_zero_hit = (ZERO_REG != 0) && (waddr == '0);
   assign w_ext_we   = wen && !w_busy && !rst && !w_zero_hit;
   assign w_we       = w_clr_we || w_ext_we;
   assign w_waddr    = w_clr_we ? w_clr_addr : waddr;
   assign w_wdata    = w_clr_we ? '0 : wdata;

   // Storage carries no reset so it can map onto RAM/LUTRAM.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_rf[w_waddr] <= w_wdata;
      end
   end

   for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_ra;
      logic [DATA_WIDTH-1:0] w_rd;

      assign w_ra = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
         w_rd = r_rf[w_ra];
         if (w_busy) begin
            w_rd = '0;
         end else if ((ZERO_REG != 0) && (w_ra == '0)) begin
            w_rd = '0;
         end else if ((BYPASS != 0) && wen && (w_ra == waddr)) begin
            w_rd = wdata;
         end
      end

      assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = w_rd;
   end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: default build plus ZERO_REG=0 and BYPASS=0 builds on shared stimulus.
module tb_regfile_multiport;

   logic        clk;
   logic        rst;
   logic        wen;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [9:0]  raddr;

   logic [63:0] m_rdata, z_rdata, b_rdata;
   logic        m_busy, z_busy, b_busy;
   logic        m_drop, z_drop, b_drop;

   int n_chk = 0;
   int n_err = 0;
   int n_cyc;

   regfile_multiport u_dut (
      .clk (clk), .rst (rst), .wen (wen), .waddr (waddr), .wdata (wdata),
      .raddr (raddr), .rdata (m_rdata), .busy (m_busy), .wr_drop (m_drop)
   );

   regfile_multiport #(.ZERO_REG (0)) u_nz (
      .clk (clk), .rst (rst), .wen (wen), .waddr (waddr), .wdata (wdata),
      .raddr (raddr), .rdata (z_rdata), .busy (z_busy), .wr_drop (z_drop)
   );

   regfile_multiport #(.BYPASS (0)) u_nb (
      .clk (clk), .rst (rst), .wen (wen), .waddr (waddr), .wdata (wdata),
      .raddr (raddr), .rdata (b_rdata), .busy (b_busy), .wr_drop (b_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
      raddr = {a1, a0};
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      wen = 1'b1; waddr = a; wdata = d;
      step();
      wen = 1'b0;
   endtask

   // Counts cycles with busy high, bounded so a stuck sequencer still reaches the summary.
   task automatic wait_clear(output int n);
      n = 0;
      while (m_busy && n < 200) begin
         n++;
         step();
      end
   endtask

   initial begin
      rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; raddr = '0;

      // Reset then idle
      step(); step(); step();
      check("rst_busy", {31'd0, m_busy}, 32'd1);
      check("rst_drop", {31'd0, m_drop}, 32'd0);
      check("rst_rdata", m_rdata[31:0], 32'd0);
      rst = 1'b0;
      wait_clear(n_cyc);
      check("busy_cycles", n_cyc, 32'd32);
      check("busy_nz_after", {31'd0, z_busy}, 32'd0);
      for (int a = 0; a < 32; a++) begin
         rd(5'(a), 5'(31 - a));
         check($sformatf("idle_p0_r%0d", a), m_rdata[31:0], 32'd0);
         check($sformatf("idle_p1_r%0d", 31 - a), m_rdata[63:32], 32'd0);
      end

      // Write/read with bypass
      rd(5'd5, 5'd6);
      wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; #1;
      check("byp_p0_same", m_rdata[31:0], 32'hDEADBEEF);
      check("byp_p1_same", m_rdata[63:32], 32'd0);
      check("nb_p0_same", b_rdata[31:0], 32'd0);
      step(); wen = 1'b0; #1;
      check("wr_p0_next", m_rdata[31:0], 32'hDEADBEEF);
      check("wr_p1_next", m_rdata[63:32], 32'd0);
      check("nb_p0_next", b_rdata[31:0], 32'hDEADBEEF);
      rd(5'd5, 5'd5);
      check("same_addr_p1", m_rdata[63:32], 32'hDEADBEEF);

      // BYPASS=0: old value in the write cycle, new value afterwards
      rd(5'd7, 5'd6);
      wen = 1'b1; waddr = 5'd7; wdata = 32'h55; #1;
      check("nb_r7_same", b_rdata[31:0], 32'd0);
      check("byp_r7_same", m_rdata[31:0], 32'h55);
      step(); wen = 1'b0; #1;
      check("nb_r7_next", b_rdata[31:0], 32'h55);

      // Zero register
      rd(5'd0, 5'd0);
      wen = 1'b1; waddr = 5'd0; wdata = 32'h12345678; #1;
      check("zr_p0_same", m_rdata[31:0], 32'd0);
      check("zr_p1_same", m_rdata[63:32], 32'd0);
      check("nz_p0_same", z_rdata[31:0], 32'h12345678);
      step(); wen = 1'b0; #1;
      check("zr_p0_next", m_rdata[31:0], 32'd0);
      check("zr_p1_next", m_rdata[63:32], 32'd0);
      check("zr_drop", {31'd0, m_drop}, 32'd0);
      check("nz_p0_next", z_rdata[31:0], 32'h12345678);

      // Write during clear
      wr(5'd3, 32'h77);
      rd(5'd3, 5'd5);
      check("r3_pre", m_rdata[31:0], 32'h77);
      rst = 1'b1; step(); rst = 1'b0;
      for (int i = 1; i < 10; i++) step();
      wen = 1'b1; waddr = 5'd3; wdata = 32'hAA; #1;
      check("clr_drop_before", {31'd0, m_drop}, 32'd0);
      check("clr_rdata_busy", m_rdata[31:0], 32'd0);
      step(); wen = 1'b0; #1;
      check("clr_drop_pulse", {31'd0, m_drop}, 32'd1);
      step();
      check("clr_drop_after", {31'd0, m_drop}, 32'd0);
      wait_clear(n_cyc);
      check("clr_busy_rest", n_cyc, 32'd21);
      rd(5'd3, 5'd5);
      check("clr_r3", m_rdata[31:0], 32'd0);
      check("clr_r5", m_rdata[63:32], 32'd0);

      // Mid-clear reset, with rst and wen together
      wr(5'd9, 32'h99);
      wr(5'd31, 32'h31);
      rd(5'd9, 5'd31);
      check("pre_r9", m_rdata[31:0], 32'h99);
      check("pre_r31", m_rdata[63:32], 32'h31);
      rst = 1'b1; wen = 1'b1; waddr = 5'd9; wdata = 32'hBAD;
      step();
      rst = 1'b0; wen = 1'b0;
      check("rstwen_drop", {31'd0, m_drop}, 32'd0);
      check("rstwen_busy", {31'd0, m_busy}, 32'd1);
      for (int i = 1; i < 20; i++) step();
      rst = 1'b1; step(); rst = 1'b0;
      wait_clear(n_cyc);
      check("mid_busy_cycles", n_cyc, 32'd32);
      for (int a = 0; a < 32; a += 2) begin
         rd(5'(a), 5'(a + 1));
         check($sformatf("mid_r%0d", a), m_rdata[31:0], 32'd0);
         check($sformatf("mid_r%0d", a + 1), m_rdata[63:32], 32'd0);
      end
      rd(5'd9, 5'd31);
      check("mid_nz_r9", z_rdata[31:0], 32'd0);
      check("mid_nb_r31", b_rdata[63:32], 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
